pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, a 2-entry skid buffer, flush, and a stall-cycle counter. It generalises the fixed-format stage latch between decode and execute: any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it with its own payload width and bubble encoding. Stalls are replaced by per-stage backpressure, and flushes by a dedicated input. When empty, the stage presents a configurable NOP payload downstream.

## Interface
- DATA_W, 32, payload width in bits (the stage bundle is concatenated by the instantiator)
- NOP_VALUE, {DATA_W{1'b0}}, payload presented on dn_data while no entry is valid (bubble)
- CNT_W, 16, width of stall_cycles
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous drop of all held entries
- clr_stats  input  1  synchronous clear of stall_cycles
- up_valid  input  1  upstream offers up_data
- up_ready  output  1  stage accepts this cycle
- up_data  input  DATA_W  upstream payload
- dn_valid  output  1  dn_data holds a valid entry
- dn_ready  input  1  downstream consumes this cycle
- dn_data  output  DATA_W  head payload, or NOP_VALUE when empty
- count  output  2  occupancy, 0..2
- stall_cycles  output  CNT_W  saturating count of cycles with dn_valid=1 and dn_ready=0

## Operation
- push = up_valid & up_ready; pop = dn_valid & dn_ready.
- Storage consists of a main register (drives dn_data) and a skid register.
- States are encoded by count:
  - EMPTY (0): push -> ONE (main <= up_data).
  - ONE (1):
    - push & pop -> ONE (main <= up_data).
    - push & !pop -> FULL (skid <= up_data).
    - !push & pop -> EMPTY.
    - otherwise hold.
  - FULL (2): up_ready=0, so push is impossible; pop -> ONE (main <= skid); otherwise hold.
- Register outputs:
  - up_ready is a register equal to (next count != 2).
  - dn_valid is a register equal to (next count != 0).
- dn_data is NOP_VALUE whenever EMPTY. Main is loaded with NOP_VALUE on the cycle it becomes empty.
- Payload is never modified; order is strictly FIFO.
- flush has priority over push and pop. Next cycle: EMPTY, dn_valid=0, dn_data=NOP_VALUE, up_ready=1. A push coincident with flush is discarded.
- stall_cycles:
  - Increments each cycle dn_valid & !dn_ready and saturates at all-ones.
  - clr_stats clears it; clr_stats wins over a coincident increment.
  - flush does not affect it.
- Reset values: count=0, dn_valid=0, up_ready=1, dn_data=NOP_VALUE, stall_cycles=0. The skid contents are don't-care but are reset to NOP_VALUE.
- Reset asserted mid-operation drops all entries immediately and asynchronously.

## Timing
- Latency: up_data pushed on edge N appears on dn_data with dn_valid=1 after edge N.
- Throughput is 1 entry/cycle sustained while dn_ready=1.
- No combinational path from up_* to dn_*, or from dn_ready to up_ready (with skid).
- After dn_ready deasserts, at most one further push is absorbed (into skid). up_ready falls the following cycle.
- After dn_ready reasserts from FULL, up_ready returns to 1 one cycle later.

## Configuration
- PIPE_SKID_EN defined: 2-entry skid behaviour as above; count ranges 0..2.
- PIPE_SKID_EN undefined:
  - Single main register only; FULL is unreachable and count is 0..1.
  - up_ready = !dn_valid | dn_ready | flush, combinational. This introduces a dn_ready->up_ready path.
  - Latency, flush, bubble and counter behaviour are unchanged.

## Test plan
- Reset, then idle: dn_valid=0, dn_data=NOP_VALUE, up_ready=1, count=0, stall_cycles=0.
- Stream 0x11,0x22,0x33 with dn_ready=1: dn_data shows 0x11,0x22,0x33 on consecutive cycles, each one cycle after its push; count stays 1.
- Backpressure (skid build):
  - Push 0xA0 then 0xA1 with dn_ready=0: count=2, up_ready=0, dn_data=0xA0, stall_cycles increments per cycle.
  - Then dn_ready=1: 0xA0, 0xA1 pop in order and count returns to 0.
  - Without PIPE_SKID_EN, 0xA1 is held off (up_ready=0) until 0xA0 pops.
- Flush while FULL with a concurrent up_valid=1, up_data=0xFF: next cycle count=0, dn_data=NOP_VALUE, and 0xFF never appears.
- CNT_W=4 with dn_valid=1 and dn_ready=0 for 20 cycles:
  - stall_cycles saturates at 15.
  - clr_stats coincident with a stall cycle yields 0.
- Assert rst asynchronously between edges while count=2: outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready payload channel between pipeline stages.
// The producer uses the master modport and the consumer uses the slave modport.
interface pipe_skid_reg_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, bubble payload and stall counter.
// Define PIPE_SKID_EN for the registered-ready 2-entry skid variant; otherwise a single register with combinational ready.
module pipe_skid_reg #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int                CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             clr_stats,
  pipe_skid_reg_if.slave   up,
  pipe_skid_reg_if.master  dn,
  output logic [1:0]       count,
  output logic [CNT_W-1:0] stall_cycles
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]        cnt_p0, cnt_nxt;
  logic              vld_p0;
  logic [DATA_W-1:0] main_p0, main_nxt;
  logic [CNT_W-1:0]  stall_p0;
  logic              push, pop;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skid_p0, skid_nxt;
  logic              rdy_p0;

  assign up.ready = rdy_p0;
`else
  assign up.ready = !vld_p0 | dn.ready | flush;
`endif

  assign push = up.valid & up.ready;
  assign pop  = vld_p0 & dn.ready;

  always_comb begin
    cnt_nxt  = cnt_p0;
    main_nxt = main_p0;
`ifdef PIPE_SKID_EN
    skid_nxt = skid_p0;
`endif
    if (flush) begin
      cnt_nxt  = 2'd0;
      main_nxt = NOP_VALUE;
    end else begin
      case (cnt_p0)
        2'd0: begin
          if (push) begin
            cnt_nxt  = 2'd1;
            main_nxt = up.data;
          end
        end
        2'd1: begin
          if (push && pop) begin
            main_nxt = up.data;
          end
`ifdef PIPE_SKID_EN
          else if (push) begin
            cnt_nxt  = 2'd2;
            skid_nxt = up.data;
          end
`endif
          else if (pop) begin
            cnt_nxt  = 2'd0;
            main_nxt = NOP_VALUE;
          end
        end
`ifdef PIPE_SKID_EN
        2'd2: begin
          if (pop) begin
            cnt_nxt  = 2'd1;
            main_nxt = skid_p0;
          end
        end
`endif
        default: begin
          cnt_nxt = cnt_p0;
        end
      endcase
    end
  end

  // stage p0: occupancy, handshake flags and stall statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0   <= 2'd0;
      vld_p0   <= 1'b0;
      stall_p0 <= '0;
`ifdef PIPE_SKID_EN
      rdy_p0   <= 1'b1;
`endif
    end else begin
      cnt_p0 <= cnt_nxt;
      vld_p0 <= (cnt_nxt != 2'd0);
`ifdef PIPE_SKID_EN
      rdy_p0 <= (cnt_nxt != 2'd2);
`endif
      if (clr_stats) begin
        stall_p0 <= '0;
      end else if (vld_p0 && !dn.ready) begin
        stall_p0 <= sat_inc(stall_p0);
      end
    end
  end

  // stage p0: payload storage, reset to the bubble so dn_data is NOP_VALUE when empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_p0 <= NOP_VALUE;
`ifdef PIPE_SKID_EN
      skid_p0 <= NOP_VALUE;
`endif
    end else begin
      main_p0 <= main_nxt;
`ifdef PIPE_SKID_EN
      skid_p0 <= skid_nxt;
`endif
    end
  end

  assign dn.valid     = vld_p0;
  assign dn.data      = main_p0;
  assign count        = cnt_p0;
  assign stall_cycles = stall_p0;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomised and directed bench for pipe_skid_reg against a queue-based reference model.
module tb_pipe_skid_reg;
  localparam int          DW  = 8;
  localparam int          CW  = 4;
  localparam logic [7:0]  NOP = 8'hEE;
`ifdef PIPE_SKID_EN
  localparam int          CAP = 2;
`else
  localparam int          CAP = 1;
`endif

  logic          clk;
  logic          rst;
  logic          flush;
  logic          clr_stats;
  logic [1:0]    count;
  logic [CW-1:0] stall_cycles;

  pipe_skid_reg_if #(.DATA_W(DW)) up_if ();
  pipe_skid_reg_if #(.DATA_W(DW)) dn_if ();

  pipe_skid_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .clr_stats    (clr_stats),
    .up           (up_if),
    .dn           (dn_if),
    .count        (count),
    .stall_cycles (stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         total = 0;
  int         bad   = 0;
  bit         chk_en = 0;
  logic [7:0] m_q[$];
  int         m_stall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_head();
    return (m_q.size() != 0) ? m_q[0] : NOP;
  endfunction

  function automatic bit m_ready();
    if (CAP == 2) return m_q.size() != 2;
    return (m_q.size() == 0) || dn_if.ready || flush;
  endfunction

  // Reference: a FIFO of at most CAP payloads
  always @(posedge clk or posedge rst) begin : model
    bit v, pu, po;
    if (rst) begin
      m_q.delete();
      m_stall = 0;
    end else begin
      v  = (m_q.size() != 0);
      pu = up_if.valid && m_ready();
      po = v && dn_if.ready;
      if (clr_stats) m_stall = 0;
      else if (v && !dn_if.ready && m_stall < 15) m_stall++;
      if (flush) m_q.delete();
      else begin
        if (po) void'(m_q.pop_front());
        if (pu) m_q.push_back(up_if.data);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("dn_valid", 32'(dn_if.valid), 32'(m_q.size() != 0));
      chk("dn_data", 32'(dn_if.data), 32'(m_head()));
      chk("up_ready", 32'(up_if.ready), 32'(m_ready()));
      chk("count", 32'(count), 32'(m_q.size()));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    end
  end

  task automatic step(input bit uv, input logic [7:0] ud, input bit dr, input bit fl, input bit cl);
    up_if.valid = uv;
    up_if.data  = ud;
    dn_if.ready = dr;
    flush       = fl;
    clr_stats   = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;
    flush       = 1'b0;
    clr_stats   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1;

    chk("idle_valid", 32'(dn_if.valid), 32'd0);
    chk("idle_data", 32'(dn_if.data), 32'hEE);
    chk("idle_ready", 32'(up_if.ready), 32'd1);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_stall", 32'(stall_cycles), 32'd0);

    step(1, 8'h11, 1, 0, 0);
    chk("stream0", 32'(dn_if.data), 32'h11);
    chk("stream0_model", 32'(m_head()), 32'h11);
    step(1, 8'h22, 1, 0, 0);
    chk("stream1", 32'(dn_if.data), 32'h22);
    step(1, 8'h33, 1, 0, 0);
    chk("stream2", 32'(dn_if.data), 32'h33);
    chk("stream_count", 32'(count), 32'd1);
    step(0, 8'h00, 1, 0, 1);
    chk("drain_count", 32'(count), 32'd0);

    step(1, 8'hA0, 0, 0, 0);
    step(1, 8'hA1, 0, 0, 0);
    step(1, 8'hA1, 0, 0, 0);
    chk("bp_count", 32'(count), 32'(CAP));
    chk("bp_count_model", 32'(m_q.size()), 32'(CAP));
    chk("bp_ready", 32'(up_if.ready), 32'd0);
    chk("bp_head", 32'(dn_if.data), 32'hA0);
    chk("bp_stall", 32'(stall_cycles), 32'd2);
`ifdef PIPE_SKID_EN
    step(0, 8'h00, 1, 0, 0);
`else
    step(1, 8'hA1, 1, 0, 0);
`endif
    chk("bp_pop1", 32'(dn_if.data), 32'hA1);
    step(0, 8'h00, 1, 0, 0);
    chk("bp_pop2_count", 32'(count), 32'd0);
    chk("bp_pop2_data", 32'(dn_if.data), 32'hEE);

    step(1, 8'hB0, 0, 0, 0);
    step(1, 8'hB1, 0, 0, 0);
    step(1, 8'hFF, 0, 1, 0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_data", 32'(dn_if.data), 32'hEE);
    chk("flush_ready", 32'(up_if.ready), 32'd1);
    step(0, 8'h00, 1, 0, 0);
    chk("flush_no_ff", 32'(dn_if.valid), 32'd0);

    step(1, 8'hC0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 8'h00, 0, 0, 0);
    chk("sat_stall", 32'(stall_cycles), 32'd15);
    chk("sat_model", 32'(m_stall), 32'd15);
    step(0, 8'h00, 0, 0, 1);
    chk("clr_stall", 32'(stall_cycles), 32'd0);
    step(0, 8'h00, 0, 0, 0);
    chk("after_clr", 32'(stall_cycles), 32'd1);

    step(1, 8'hC1, 0, 0, 0);
    up_if.valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(dn_if.valid), 32'd0);
    chk("arst_ready", 32'(up_if.ready), 32'd1);
    chk("arst_data", 32'(dn_if.data), 32'hEE);
    chk("arst_stall", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 1500; i++) begin
      step(bit'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0);
    end
    step(0, 8'h00, 1, 0, 0);
    @(negedge clk);
    chk_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
